spi_fifo_gen: RTL and testbench

SPI_FIFO_GEN -- requirements
Module: spi_fifo_gen

---
 rtl/spi_pkg.sv | 6 +
 rtl/spi_fifo_mem.sv | 21 ++
 rtl/spi_fifo_gen.sv | 105 ++++++++++
 tb/tb_spi_fifo_gen.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI FIFO defaults and the byte type used by SPI datapaths.
package spi_pkg;
    localparam int SPI_FIFO_DATA_W = 8;
    localparam int SPI_FIFO_DEPTH  = 8;
    typedef logic [7:0] spi_byte_t;
endpackage

// File: rtl/spi_fifo_mem.sv
// FIFO storage: one write port, one registered read port, no reset.
module spi_fifo_mem #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/spi_fifo_gen.sv
// Synchronous FIFO with registered read data, count and threshold flags.
// Define SPI_FIFO_ERR_EN to add sticky overflow/underflow flags with err_clr_i.
module spi_fifo_gen
    import spi_pkg::*;
#(
    parameter  int DATA_W = SPI_FIFO_DATA_W,
    parameter  int DEPTH  = SPI_FIFO_DEPTH,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic [AW:0]       count_o,
    output logic              full_o,
    output logic              empty_o,
    input  logic [AW:0]       afull_thr_i,
    input  logic [AW:0]       aempty_thr_i,
    output logic              almost_full_o,
    output logic              almost_empty_o
`ifdef SPI_FIFO_ERR_EN
    ,
    output logic              overflow_o,
    output logic              underflow_o,
    input  logic              err_clr_i
`endif
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_rd_valid;
    logic              r_rd_seen;
    logic              w_wr_acc, w_rd_acc;
    logic [DATA_W-1:0] w_mem_q;

    assign empty_o        = (r_count == '0);
    assign full_o         = (r_count == FULL_CNT);
    assign count_o        = r_count;
    assign rd_valid_o     = r_rd_valid;
    assign almost_full_o  = (r_count >= afull_thr_i);
    assign almost_empty_o = (r_count <= aempty_thr_i);

    // Read needs stored data (no fall-through); a full FIFO still takes a write paired with a read.
    assign w_rd_acc = rd_en_i && !empty_o;
    assign w_wr_acc = wr_en_i && (!full_o || w_rd_acc);

    spi_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc && !flush_i),
        .i_waddr (r_wr_ptr),
        .i_wdata (wr_data_i),
        .i_re    (w_rd_acc && !flush_i),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_q)
    );

    // Memory output is unreset, so mask it to zero until the first read after reset.
    assign rd_data_o = r_rd_seen ? w_mem_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_seen  <= 1'b0;
        end else if (flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) r_rd_seen <= 1'b1;
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr_acc && !w_rd_acc)      r_count <= r_count + 1'b1;
            else if (!w_wr_acc && w_rd_acc) r_count <= r_count - 1'b1;
        end
    end

`ifdef SPI_FIFO_ERR_EN
    logic r_ovf, r_unf;
    assign overflow_o  = r_ovf;
    assign underflow_o = r_unf;

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (wr_en_i && !w_wr_acc) r_ovf <= 1'b1;
            else if (err_clr_i)       r_ovf <= 1'b0;
            if (rd_en_i && empty_o)   r_unf <= 1'b1;
            else if (err_clr_i)       r_unf <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_spi_fifo_gen.sv
// Directed bench for spi_fifo_gen: queue-based reference model plus literal spot checks.
module tb_spi_fifo_gen;
    import spi_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush_i = 1'b0, wr_en_i = 1'b0, rd_en_i = 1'b0;
    spi_byte_t  wr_data_i = '0;
    spi_byte_t  rd_data_o;
    logic       rd_valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
    logic [3:0] count_o;
    logic [3:0] afull_thr_i = 4'd6, aempty_thr_i = 4'd1;
`ifdef SPI_FIFO_ERR_EN
    logic       overflow_o, underflow_o;
    logic       err_clr_i = 1'b0;
`endif

    int vecs = 0;
    int errs = 0;

    spi_fifo_gen #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
        .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
        .afull_thr_i(afull_thr_i), .aempty_thr_i(aempty_thr_i),
        .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o)
`ifdef SPI_FIFO_ERR_EN
        , .overflow_o(overflow_o), .underflow_o(underflow_o), .err_clr_i(err_clr_i)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words plus last delivered word.
    spi_byte_t q[$];
    spi_byte_t m_data = '0;
    bit        m_vld  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_data = '0;
            m_vld  = 1'b0;
        end else begin
            bit rd_ok, wr_ok;
            m_vld = 1'b0;
            if (flush_i) q.delete();
            else begin
                rd_ok = rd_en_i && (q.size() > 0);
                wr_ok = wr_en_i && ((q.size() < DEPTH) || rd_ok);
                if (rd_ok) begin m_data = q.pop_front(); m_vld = 1'b1; end
                if (wr_ok) q.push_back(wr_data_i);
            end
        end
    end

    always @(negedge clk) begin
        chk("count", 32'(count_o), 32'(q.size()));
        chk("empty", 32'(empty_o), 32'(q.size() == 0));
        chk("full", 32'(full_o), 32'(q.size() == DEPTH));
        chk("afull", 32'(almost_full_o), 32'(q.size() >= int'(afull_thr_i)));
        chk("aempty", 32'(almost_empty_o), 32'(q.size() <= int'(aempty_thr_i)));
        chk("rd_valid", 32'(rd_valid_o), 32'(m_vld));
        chk("rd_data", 32'(rd_data_o), 32'(m_data));
    end

    // Applies inputs for one edge; returns 1 time unit after that edge.
    task automatic step(input bit wr, input spi_byte_t d, input bit rd, input bit fl);
        wr_en_i = wr; wr_data_i = d; rd_en_i = rd; flush_i = fl;
        @(posedge clk); #1;
    endtask

    initial begin
        spi_byte_t held;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count_o), 0);
        chk("rst_empty", 32'(empty_o), 1);
        chk("rst_full", 32'(full_o), 0);
        chk("rst_rd_data", 32'(rd_data_o), 0);
        chk("rst_rd_valid", 32'(rd_valid_o), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) step(1, spi_byte_t'(8'h11 + i), 0, 0);
        chk("fill_full", 32'(full_o), 1);
        chk("fill_count", 32'(count_o), 8);
        step(1, 8'h99, 0, 0);
        chk("ovf_count", 32'(count_o), 8);

        for (int i = 0; i < 8; i++) begin
            step(0, 8'h00, 1, 0);
            chk("rd_seq", 32'(rd_data_o), 32'(8'h11 + i));
            chk("rd_seq_vld", 32'(rd_valid_o), 1);
        end
        chk("drain_empty", 32'(empty_o), 1);
        step(0, 8'h00, 1, 0);
        chk("unf_vld", 32'(rd_valid_o), 0);

        for (int i = 0; i < 8; i++) step(1, spi_byte_t'(8'h21 + i), 0, 0);
        step(1, 8'hAA, 1, 0);
        chk("full_rw_count", 32'(count_o), 8);
        chk("full_rw_data", 32'(rd_data_o), 32'h21);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
        chk("aa_last", 32'(rd_data_o), 32'hAA);

        step(1, 8'h55, 1, 0);
        chk("empty_rw_count", 32'(count_o), 1);
        chk("empty_rw_vld", 32'(rd_valid_o), 0);
        step(0, 8'h00, 1, 0);
        chk("empty_rw_data", 32'(rd_data_o), 32'h55);

        for (int i = 0; i < 6; i++) begin
            step(1, spi_byte_t'(8'h60 + i), 0, 0);
            if (i == 0) chk("aempty_at1", 32'(almost_empty_o), 1);
            if (i == 1) chk("aempty_at2", 32'(almost_empty_o), 0);
            if (i == 4) chk("afull_at5", 32'(almost_full_o), 0);
            if (i == 5) chk("afull_at6", 32'(almost_full_o), 1);
        end
        held = rd_data_o;
        step(1, 8'hEE, 1, 1);
        chk("flush_count", 32'(count_o), 0);
        chk("flush_data", 32'(rd_data_o), 32'h55);
        chk("flush_hold", 32'(rd_data_o), 32'(held));
        chk("flush_vld", 32'(rd_valid_o), 0);

        for (int i = 0; i < 5; i++) step(1, spi_byte_t'(8'h31 + i), 0, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);
        for (int i = 0; i < 6; i++) step(1, spi_byte_t'(8'h41 + i), 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 8'h00, 1, 0);
            chk("wrap_seq", 32'(rd_data_o), 32'(8'h41 + i));
        end

        step(1, 8'h51, 0, 0);
        wr_en_i = 1'b1; wr_data_i = 8'h52;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(count_o), 0);
        chk("midrst_empty", 32'(empty_o), 1);
        chk("midrst_data", 32'(rd_data_o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, 8'h00, 1, 0);
        chk("post_rst_vld", 32'(rd_valid_o), 0);
        step(1, 8'h77, 0, 0);
        step(0, 8'h00, 1, 0);
        chk("post_rst_data", 32'(rd_data_o), 32'h77);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
